// File: rtl/ex_forward_hazard_unit.sv
// Execute-stage forwarding select generator and load-use stall detector.
// A shadow copy of the destination/control fields tracks the instructions ahead of ID.
module ex_forward_hazard_unit #(
  parameter int NB_REG = 5,
  parameter int NB_CNT = 32
) (
  input  logic              clock_i,
  input  logic              reset_n_i,
  input  logic              enable_i,
  input  logic              flush_i,
  input  logic [NB_REG-1:0] id_rs_i,
  input  logic [NB_REG-1:0] id_rt_i,
  input  logic              id_uses_rs_i,
  input  logic              id_uses_rt_i,
  input  logic [NB_REG-1:0] id_write_reg_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  output logic [1:0]        forward_signal_regA,
  output logic [1:0]        forward_signal_regB,
  output logic              stall_o,
  output logic [NB_CNT-1:0] stall_count_o,
  output logic [NB_CNT-1:0] flush_count_o
);

  localparam logic [NB_REG-1:0] REG_ZERO  = {NB_REG{1'b0}};
  localparam logic [1:0]        SEL_RF    = 2'b00;
  localparam logic [1:0]        SEL_EXMEM = 2'b01;
  localparam logic [1:0]        SEL_MEMWB = 2'b10;

  // Shadow of the instruction currently in EX and the one in EX/MEM.
  logic [NB_REG-1:0] r_ex_dest;
  logic              r_ex_reg_write;
  logic              r_ex_mem_read;
  logic [NB_REG-1:0] r_mem_dest;
  logic              r_mem_reg_write;

  logic [1:0]        r_sel_a;
  logic [1:0]        r_sel_b;
  logic [NB_CNT-1:0] r_stall_cnt;
  logic [NB_CNT-1:0] r_flush_cnt;

  logic              w_hazard;
  logic              w_stall;
  logic              w_bubble;
  logic [1:0]        w_sel_a;
  logic [1:0]        w_sel_b;

  // Newest producer wins: the instruction leaving EX is checked before the one leaving EX/MEM.
  function automatic logic [1:0] f_fwd_sel(
    input logic [NB_REG-1:0] src,
    input logic              uses,
    input logic              ex_rw,
    input logic [NB_REG-1:0] ex_dest,
    input logic              mem_rw,
    input logic [NB_REG-1:0] mem_dest
  );
    logic [1:0] sel;
    sel = SEL_RF;
    if (uses && ex_rw && (ex_dest != REG_ZERO) && (ex_dest == src)) begin
      sel = SEL_EXMEM;
    end else if (uses && mem_rw && (mem_dest != REG_ZERO) && (mem_dest == src)) begin
      sel = SEL_MEMWB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Load-use detection and select computation for the entry about to enter EX.
  always_comb begin
    w_hazard = 1'b0;
    w_stall  = 1'b0;
    w_bubble = 1'b0;
    w_sel_a  = SEL_RF;
    w_sel_b  = SEL_RF;
    if (r_ex_mem_read && (r_ex_dest != REG_ZERO)) begin
      w_hazard = (id_uses_rs_i && (id_rs_i == r_ex_dest)) ||
                 (id_uses_rt_i && (id_rt_i == r_ex_dest));
    end else begin
      w_hazard = 1'b0;
    end
    // A flushed instruction cannot be waiting on anything, so flush suppresses the stall.
    w_stall  = w_hazard & enable_i & ~flush_i;
    w_bubble = flush_i | w_stall;
    if (w_bubble) begin
      w_sel_a = SEL_RF;
      w_sel_b = SEL_RF;
    end else begin
      w_sel_a = f_fwd_sel(id_rs_i, id_uses_rs_i, r_ex_reg_write, r_ex_dest,
                          r_mem_reg_write, r_mem_dest);
      w_sel_b = f_fwd_sel(id_rt_i, id_uses_rt_i, r_ex_reg_write, r_ex_dest,
                          r_mem_reg_write, r_mem_dest);
    end
  end

  // Shadow pipeline advance; a bubble is inserted on stall or flush.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_ex_dest       <= REG_ZERO;
      r_ex_reg_write  <= 1'b0;
      r_ex_mem_read   <= 1'b0;
      r_mem_dest      <= REG_ZERO;
      r_mem_reg_write <= 1'b0;
    end else if (enable_i) begin
      r_mem_dest      <= r_ex_dest;
      r_mem_reg_write <= r_ex_reg_write;
      if (w_bubble) begin
        r_ex_dest      <= REG_ZERO;
        r_ex_reg_write <= 1'b0;
        r_ex_mem_read  <= 1'b0;
      end else begin
        r_ex_dest      <= id_write_reg_i;
        r_ex_reg_write <= id_reg_write_i;
        r_ex_mem_read  <= id_mem_read_i;
      end
    end
  end

  // Registered selects line up with the EX cycle of their instruction.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_sel_a <= SEL_RF;
      r_sel_b <= SEL_RF;
    end else if (enable_i) begin
      r_sel_a <= w_sel_a;
      r_sel_b <= w_sel_b;
    end
  end

  // Debug counters; they wrap naturally at the counter width.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_stall_cnt <= {NB_CNT{1'b0}};
      r_flush_cnt <= {NB_CNT{1'b0}};
    end else if (enable_i) begin
      r_stall_cnt <= r_stall_cnt + {{(NB_CNT-1){1'b0}}, w_stall};
      r_flush_cnt <= r_flush_cnt + {{(NB_CNT-1){1'b0}}, flush_i};
    end
  end

  assign forward_signal_regA = r_sel_a;
  assign forward_signal_regB = r_sel_b;
  assign stall_o             = w_stall;
  assign stall_count_o       = r_stall_cnt;
  assign flush_count_o       = r_flush_cnt;

endmodule

// File: tb/tb_ex_forward_hazard_unit.sv
// Self-checking bench: directed vector table, freeze/reset sequences, and random
// traffic checked against a list-of-producers reference model.
module tb_ex_forward_hazard_unit;

  localparam int NB_REG = 5;
  localparam int NB_CNT = 32;

  logic              clock_i = 1'b0;
  logic              reset_n_i;
  logic              enable_i;
  logic              flush_i;
  logic [NB_REG-1:0] id_rs_i;
  logic [NB_REG-1:0] id_rt_i;
  logic              id_uses_rs_i;
  logic              id_uses_rt_i;
  logic [NB_REG-1:0] id_write_reg_i;
  logic              id_reg_write_i;
  logic              id_mem_read_i;
  logic [1:0]        forward_signal_regA;
  logic [1:0]        forward_signal_regB;
  logic              stall_o;
  logic [NB_CNT-1:0] stall_count_o;
  logic [NB_CNT-1:0] flush_count_o;

  ex_forward_hazard_unit #(.NB_REG(NB_REG), .NB_CNT(NB_CNT)) dut (
    .clock_i(clock_i), .reset_n_i(reset_n_i), .enable_i(enable_i), .flush_i(flush_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_uses_rs_i(id_uses_rs_i),
    .id_uses_rt_i(id_uses_rt_i), .id_write_reg_i(id_write_reg_i),
    .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .forward_signal_regA(forward_signal_regA), .forward_signal_regB(forward_signal_regB),
    .stall_o(stall_o), .stall_count_o(stall_count_o), .flush_count_o(flush_count_o)
  );

  always #5 clock_i = ~clock_i;

  // Reference model: pipe[0] is the instruction in EX, pipe[1] the one ahead of it.
  typedef struct packed {
    logic [NB_REG-1:0] dest;
    logic              rw;
    logic              mr;
  } instr_t;

  instr_t      pipe [2];
  logic [1:0]  m_a, m_b;
  logic [31:0] m_sc, m_fc;
  logic        s_stall;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic              flush;
    logic [NB_REG-1:0] rs, rt, wr;
    logic              urs, urt, rw, mr;
    logic              es;
    logic [1:0]        ea, eb;
    logic [31:0]       esc, efc;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(input logic fl, input int rs, input logic urs, input int rt,
                              input logic urt, input int wr, input logic rw, input logic mr,
                              input logic es, input int ea, input int eb, input int esc,
                              input int efc);
    vec_t v;
    v.flush = fl; v.rs = NB_REG'(rs); v.urs = urs; v.rt = NB_REG'(rt); v.urt = urt;
    v.wr = NB_REG'(wr); v.rw = rw; v.mr = mr; v.es = es; v.ea = 2'(ea); v.eb = 2'(eb);
    v.esc = 32'(esc); v.efc = 32'(efc);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Distance (1 = one ahead, 2 = two ahead) of the newest nonzero producer of src.
  function automatic logic [1:0] m_lookup(input logic [NB_REG-1:0] src, input logic uses);
    logic [1:0] res;
    res = 2'd0;
    for (int k = 1; k >= 0; k--)
      if (uses && pipe[k].rw && pipe[k].dest != 0 && pipe[k].dest == src) res = 2'(k + 1);
    return res;
  endfunction

  function automatic logic m_stall();
    return enable_i && !flush_i && pipe[0].mr && pipe[0].dest != 0 &&
           ((id_uses_rs_i && id_rs_i == pipe[0].dest) || (id_uses_rt_i && id_rt_i == pipe[0].dest));
  endfunction

  task automatic model_reset();
    pipe[0] = '0; pipe[1] = '0;
    m_a = 2'd0; m_b = 2'd0; m_sc = 32'd0; m_fc = 32'd0;
  endtask

  task automatic model_edge();
    logic st, bub;
    instr_t nw;
    if (enable_i) begin
      st  = m_stall();
      bub = st || flush_i;
      m_a = bub ? 2'd0 : m_lookup(id_rs_i, id_uses_rs_i);
      m_b = bub ? 2'd0 : m_lookup(id_rt_i, id_uses_rt_i);
      nw.dest = id_write_reg_i; nw.rw = id_reg_write_i; nw.mr = id_mem_read_i;
      pipe[1] = pipe[0];
      pipe[0] = bub ? instr_t'(0) : nw;
      m_sc = m_sc + 32'(st);
      m_fc = m_fc + 32'(flush_i);
    end
  endtask

  task automatic set_id(input logic fl, input logic [NB_REG-1:0] rs, input logic urs,
                        input logic [NB_REG-1:0] rt, input logic urt,
                        input logic [NB_REG-1:0] wr, input logic rw, input logic mr);
    flush_i = fl; id_rs_i = rs; id_uses_rs_i = urs; id_rt_i = rt; id_uses_rt_i = urt;
    id_write_reg_i = wr; id_reg_write_i = rw; id_mem_read_i = mr;
  endtask

  // One clock: check stall before the edge, selects and counters just after it.
  task automatic step(input string tag);
    #3;
    s_stall = stall_o;
    chk({tag, "_stall"}, 32'(stall_o), 32'(m_stall()));
    @(posedge clock_i);
    model_edge();
    #1;
    chk({tag, "_regA"}, 32'(forward_signal_regA), 32'(m_a));
    chk({tag, "_regB"}, 32'(forward_signal_regB), 32'(m_b));
    chk({tag, "_scnt"}, stall_count_o, m_sc);
    chk({tag, "_fcnt"}, flush_count_o, m_fc);
  endtask

  initial begin
    tbl[0]  = mk(0, 1, 1, 2, 1,  3, 1, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 3, 1, 4, 1,  6, 1, 0, 0, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 2, 1,  3, 1, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 7, 1, 3, 1,  8, 1, 0, 0, 0, 2, 0, 0);
    tbl[5]  = mk(0, 1, 1, 2, 1,  3, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1, 2, 1,  3, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 3, 1, 9, 1, 10, 1, 0, 0, 1, 0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 5, 0,  5, 1, 1, 0, 0, 0, 0, 0);
    tbl[9]  = mk(0, 5, 1, 2, 1, 11, 1, 0, 1, 0, 0, 1, 0);
    tbl[10] = mk(0, 5, 1, 2, 1, 11, 1, 0, 0, 2, 0, 1, 0);
    tbl[11] = mk(0, 1, 1, 5, 0,  5, 1, 1, 0, 0, 0, 1, 0);
    tbl[12] = mk(1, 5, 1, 2, 1, 11, 1, 0, 0, 0, 0, 1, 1);
    tbl[13] = mk(0, 5, 1, 0, 0, 12, 1, 0, 0, 2, 0, 1, 1);
    tbl[14] = mk(0, 1, 1, 0, 0,  0, 1, 1, 0, 0, 0, 1, 1);
    tbl[15] = mk(0, 0, 1, 0, 1, 13, 1, 0, 0, 0, 0, 1, 1);
    tbl[16] = mk(0, 0, 1, 0, 1, 14, 1, 0, 0, 0, 0, 1, 1);

    reset_n_i = 1'b0; enable_i = 1'b1;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    chk("rst_regA", 32'(forward_signal_regA), 32'd0);
    chk("rst_regB", 32'(forward_signal_regB), 32'd0);
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_scnt", stall_count_o, 32'd0);
    chk("rst_fcnt", flush_count_o, 32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;

    // Directed table: forwarding, priority, load-use, flush, register zero.
    for (int i = 0; i < 17; i++) begin
      set_id(tbl[i].flush, tbl[i].rs, tbl[i].urs, tbl[i].rt, tbl[i].urt,
             tbl[i].wr, tbl[i].rw, tbl[i].mr);
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_tstall", i), 32'(s_stall), 32'(tbl[i].es));
      chk($sformatf("vec%0d_tregA", i), 32'(forward_signal_regA), 32'(tbl[i].ea));
      chk($sformatf("vec%0d_tregB", i), 32'(forward_signal_regB), 32'(tbl[i].eb));
      chk($sformatf("vec%0d_tscnt", i), stall_count_o, tbl[i].esc);
      chk($sformatf("vec%0d_tfcnt", i), flush_count_o, tbl[i].efc);
    end

    // Freeze: load in EX, dependent in ID, enable low for three cycles.
    set_id(0, 1, 1, 5, 0, 5, 1, 1);
    step("frz_lw");
    enable_i = 1'b0;
    set_id(0, 5, 1, 2, 1, 11, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step($sformatf("frz%0d", i));
      chk($sformatf("frz%0d_nostall", i), 32'(s_stall), 32'd0);
      chk($sformatf("frz%0d_scnt_hold", i), stall_count_o, 32'd1);
    end
    enable_i = 1'b1;
    step("thaw");
    chk("thaw_stall_held_load", 32'(s_stall), 32'd1);
    chk("thaw_scnt", stall_count_o, 32'd2);
    step("thaw_dep");
    chk("thaw_dep_regA", 32'(forward_signal_regA), 32'd2);

    // Asynchronous reset mid-stream, then first instruction forwards nothing.
    #2;
    reset_n_i = 1'b0;
    #1;
    model_reset();
    chk("mrst_regA", 32'(forward_signal_regA), 32'd0);
    chk("mrst_regB", 32'(forward_signal_regB), 32'd0);
    chk("mrst_scnt", stall_count_o, 32'd0);
    chk("mrst_fcnt", flush_count_o, 32'd0);
    @(negedge clock_i);
    reset_n_i = 1'b1;
    set_id(0, 11, 1, 11, 1, 15, 1, 0);
    step("post_rst");
    chk("post_rst_regA", 32'(forward_signal_regA), 32'd0);

    // Random traffic over a small register range to provoke frequent hazards.
    for (int i = 0; i < 1500; i++) begin
      enable_i = ($urandom_range(0, 9) != 0);
      set_id(($urandom_range(0, 9) == 0),
             NB_REG'($urandom_range(0, 3)), 1'($urandom),
             NB_REG'($urandom_range(0, 3)), 1'($urandom),
             NB_REG'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      step("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
